// File: rtl/tag_lookup_pkg.sv
// Shared defaults and small way-vector helpers for the tag lookup pipeline.
// Way vectors are handled at a fixed maximum width and zero-extended by callers.
package tag_lookup_pkg;

    localparam int TAG_W_DEF = 25;
    localparam int WAYS_DEF  = 4;
    localparam int CNT_W_DEF = 16;

    // Largest associativity the helpers below can handle.
    localparam int WAY_VEC_MAX = 64;

    typedef logic [WAY_VEC_MAX-1:0] way_vec_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned onehot_lowest_index(input way_vec_t v);
        int unsigned idx;
        idx = 0;
        for (int i = WAY_VEC_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

    // True when two or more bits are set: clearing the lowest set bit leaves something.
    function automatic logic popcount_gt1(input way_vec_t v);
        return (v & (v - way_vec_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/tag_way_cmp.sv
// One way of the set compare: full-width tag equality qualified by the way valid bit.
module tag_way_cmp #(
    parameter int TAG_W = 25
) (
    input  logic [TAG_W-1:0] req_tag,
    input  logic [TAG_W-1:0] way_tag,
    input  logic             way_valid,
    output logic             match
);

    assign match = way_valid && (way_tag == req_tag);

endmodule

// File: rtl/tag_lookup_pipe.sv
// Two-stage set-associative tag lookup: stage 1 registers the per-way match vector,
// stage 2 registers the hit summary. Saturating hit/miss counters count output transfers.
module tag_lookup_pipe
    import tag_lookup_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int WAYS  = WAYS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [WAYS*TAG_W-1:0]    way_tags,
    input  logic [WAYS-1:0]          way_valid,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     hit,
    output logic [WAYS-1:0]          hit_vec,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic                     multi_hit,

    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    localparam int WAY_W = $clog2(WAYS);

    logic [WAYS-1:0]  cmp_vec;
    logic             s1_valid_reg;
    logic [WAYS-1:0]  s1_hit_vec_reg;
    logic             s1_adv;
    logic             s2_adv;
    logic             xfer;
    logic [WAY_W-1:0] s1_way;
    logic             s1_multi;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            tag_way_cmp #(
                .TAG_W(TAG_W)
            ) u_cmp (
                .req_tag  (req_tag),
                .way_tag  (way_tags[gi*TAG_W +: TAG_W]),
                .way_valid(way_valid[gi]),
                .match    (cmp_vec[gi])
            );
        end
    endgenerate

    // Handshake depends only on pipeline state and out_ready, never on in_valid.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign xfer     = out_valid && out_ready;

    assign s1_way   = WAY_W'(onehot_lowest_index(way_vec_t'(s1_hit_vec_reg)));
    assign s1_multi = popcount_gt1(way_vec_t'(s1_hit_vec_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_hit_vec_reg <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_hit_vec_reg <= cmp_vec;
            end
        end
    end

    // Payload only loads with a valid stage-1 entry so a stalled or idle output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            hit_vec   <= '0;
            hit_way   <= '0;
            multi_hit <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                hit       <= |s1_hit_vec_reg;
                hit_vec   <= s1_hit_vec_reg;
                hit_way   <= s1_way;
                multi_hit <= s1_multi;
            end
        end
    end

    // Clear takes priority over a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (xfer) begin
            if (hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_lookup_pipe.sv
// Scoreboard bench for tag_lookup_pipe: expected results are queued at acceptance
// and compared at each output transfer; counters tracked by a saturating model.
module tb_tag_lookup_pipe;

    localparam int TAG_W = 25;
    localparam int WAYS  = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       multi;
        logic       hit;
        logic [1:0] way;
        logic [3:0] hv;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [TAG_W-1:0]      req_tag;
    logic [WAYS*TAG_W-1:0] way_tags;
    logic [WAYS-1:0]       way_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic                  hit;
    logic [WAYS-1:0]       hit_vec;
    logic [1:0]            hit_way;
    logic                  multi_hit;
    logic                  cnt_clr;
    logic [CNT_W-1:0]      hit_cnt;
    logic [CNT_W-1:0]      miss_cnt;

    int   checks;
    int   errors;
    int   stall_seen;
    exp_t sb[$];
    logic [CNT_W-1:0] exp_hit;
    logic [CNT_W-1:0] exp_miss;
    logic held;
    exp_t snap;

    tag_lookup_pipe #(
        .TAG_W(TAG_W),
        .WAYS (WAYS),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .req_tag  (req_tag),
        .way_tags (way_tags),
        .way_valid(way_valid),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .hit      (hit),
        .hit_vec  (hit_vec),
        .hit_way  (hit_way),
        .multi_hit(multi_hit),
        .cnt_clr  (cnt_clr),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [TAG_W-1:0] rt, input logic [WAYS*TAG_W-1:0] wt,
                                   input logic [WAYS-1:0] wv);
        exp_t e;
        int   n;
        logic found;
        e     = '0;
        n     = 0;
        found = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            if (wv[j] && (wt[j*TAG_W +: TAG_W] == rt)) begin
                e.hv[j] = 1'b1;
                n++;
                if (!found) begin
                    e.way = 2'(j);
                    found = 1'b1;
                end
            end
        end
        e.hit   = (n > 0);
        e.multi = (n > 1);
        return e;
    endfunction

    function automatic logic [WAYS*TAG_W-1:0] mk_tags(input logic [TAG_W-1:0] w0, input logic [TAG_W-1:0] w1,
                                                     input logic [TAG_W-1:0] w2, input logic [TAG_W-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Monitor: push at acceptance, compare at transfer, check counters and stall stability.
    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(model(req_tag, way_tags, way_valid));
            if (in_valid && !in_ready) stall_seen++;
            chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
            chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
            if (held) chk("stall_hold", 64'({multi_hit, hit, hit_way, hit_vec}), 64'(snap));
            have = 1'b0;
            e    = '0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e    = sb.pop_front();
                    have = 1'b1;
                    chk("res_hit", 64'(hit), 64'(e.hit));
                    chk("res_hit_vec", 64'(hit_vec), 64'(e.hv));
                    chk("res_hit_way", 64'(hit_way), 64'(e.way));
                    chk("res_multi", 64'(multi_hit), 64'(e.multi));
                end
            end
            if (cnt_clr) begin
                exp_hit  = '0;
                exp_miss = '0;
            end else if (have) begin
                if (e.hit) begin
                    if (exp_hit != '1) exp_hit = exp_hit + 1'b1;
                end else begin
                    if (exp_miss != '1) exp_miss = exp_miss + 1'b1;
                end
            end
            held = out_valid && !out_ready;
            snap = {multi_hit, hit, hit_way, hit_vec};
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [TAG_W-1:0] rt, input logic [WAYS*TAG_W-1:0] wt, input logic [WAYS-1:0] wv);
        int   n;
        logic acc;
        n         = 0;
        in_valid  = 1'b1;
        req_tag   = rt;
        way_tags  = wt;
        way_valid = wv;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    // Idle cycles with junk on the request inputs, which must be ignored.
    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            req_tag   = TAG_W'($urandom);
            way_tags  = mk_tags(TAG_W'($urandom), TAG_W'($urandom), TAG_W'($urandom), TAG_W'($urandom));
            way_valid = WAYS'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        idle(2);
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    task automatic send_random();
        logic [TAG_W-1:0]      rt;
        logic [WAYS*TAG_W-1:0] wt;
        rt = TAG_W'($urandom);
        wt = '0;
        for (int j = 0; j < WAYS; j++) begin
            wt[j*TAG_W +: TAG_W] = ($urandom_range(0, 1) == 1) ? rt : TAG_W'($urandom);
        end
        send(rt, wt, WAYS'($urandom));
    endtask

    logic [WAYS*TAG_W-1:0] ref_tags;

    initial begin
        checks     = 0;
        errors     = 0;
        stall_seen = 0;
        exp_hit    = '0;
        exp_miss   = '0;
        held       = 1'b0;
        snap       = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        req_tag    = '0;
        way_tags   = '0;
        way_valid  = '0;
        ref_tags   = mk_tags(25'h0AAAAAA, 25'h1555555, 25'h0123456, 25'h1FFFFFF);

        #22;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_hit", 64'(hit), 64'(0));
        chk("rst_hit_vec", 64'(hit_vec), 64'(0));
        chk("rst_hit_way", 64'(hit_way), 64'(0));
        chk("rst_multi", 64'(multi_hit), 64'(0));
        chk("rst_cnts", 64'({hit_cnt, miss_cnt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single hit in way 2, with exact 2-cycle latency.
        send(25'h0123456, ref_tags, 4'b1111);
        in_valid = 1'b0;
        chk("lat_c1_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("lat_c2_out_valid", 64'(out_valid), 64'(1));
        chk("hit_way2", 64'(hit_way), 64'(2));
        chk("hit_vec_0100", 64'(hit_vec), 64'(4'b0100));
        drain();

        // Matching tag but invalid way is a miss.
        send(25'h0123456, ref_tags, 4'b1011);
        drain();
        chk("cnt_after_miss", 64'({hit_cnt, miss_cnt}), 64'({4'd1, 4'd1}));

        // Two valid matches: lowest index wins, multi-hit flagged.
        send(25'h0000042, mk_tags(25'h0000043, 25'h0000042, 25'h0000000, 25'h0000042), 4'b1111);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("multi_hit_way", 64'(hit_way), 64'(1));
        chk("multi_hit_flag", 64'(multi_hit), 64'(1));
        drain();

        // Random lookups under random backpressure.
        fork
            begin
                for (int i = 0; i < 20; i++) send_random();
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Eight back-to-back requests, distinct hit patterns, output stalled cycles 3-6.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [3:0]            m;
                    logic [TAG_W-1:0]      rt;
                    logic [WAYS*TAG_W-1:0] wt;
                    m  = 4'(i + 1);
                    rt = TAG_W'(32'h100 + i);
                    wt = '0;
                    for (int j = 0; j < WAYS; j++) wt[j*TAG_W +: TAG_W] = m[j] ? rt : (rt ^ 25'h1);
                    send(rt, wt, 4'b1111);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("b2b_in_ready_low", 64'(stall_seen > 0), 64'(1));

        // Hit counter saturates at 15.
        clear_counters();
        for (int i = 0; i < 20; i++) send(25'h0123456, ref_tags, 4'b1111);
        drain();
        chk("hit_cnt_sat", 64'(hit_cnt), 64'(15));

        // Clear coincident with a transfer wins.
        send(25'h1FFFFFF, ref_tags, 4'b1111);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_clr_out_valid", 64'(out_valid), 64'(1));
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_wins", 64'({hit_cnt, miss_cnt}), 64'(0));
        drain();

        // Reset with two lookups in flight.
        send(25'h1555555, ref_tags, 4'b1111);
        drain();
        send(25'h0AAAAAA, ref_tags, 4'b1111);
        send(25'h0000001, ref_tags, 4'b1111);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_cnts", 64'({hit_cnt, miss_cnt}), 64'(0));
        chk("rst_mid_hit_vec", 64'(hit_vec), 64'(0));
        sb.delete();
        exp_hit  = '0;
        exp_miss = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        chk("rel_out_valid", 64'(out_valid), 64'(0));
        send(25'h0123456, ref_tags, 4'b1111);
        drain();
        chk("post_rst_cnts", 64'({hit_cnt, miss_cnt}), 64'({4'd1, 4'd0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
